imul_fac8_0: RTL and testbench

IMUL_FAC8_0 -- requirements
Module: imul_fac8_0

---
 rtl/imul_fac8_0_if.sv | 33 +++
 rtl/imul_fac8_0.sv | 107 ++++++++++
 tb/tb_imul_fac8_0.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imul_fac8_0_if.sv
// Handshake and data bus for imul_fac8_0: input vector with valid/frame_start,
// registered output vector with valid and applied factor.
// Every lane of every branch is a signed two's-complement sample of WIDTH bits.
interface imul_fac8_0_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
);
    logic                         valid_in;
    logic                         frame_start;
    logic [DEPTH-1:0][WIDTH-1:0]  din_R_add;
    logic [DEPTH-1:0][WIDTH-1:0]  din_Q_add;
    logic [DEPTH-1:0][WIDTH-1:0]  din_R_sub;
    logic [DEPTH-1:0][WIDTH-1:0]  din_Q_sub;

    logic                         valid_out;
    logic                         fac_out;
    logic [DEPTH-1:0][WIDTH-1:0]  dout_R_add;
    logic [DEPTH-1:0][WIDTH-1:0]  dout_Q_add;
    logic [DEPTH-1:0][WIDTH-1:0]  dout_R_sub;
    logic [DEPTH-1:0][WIDTH-1:0]  dout_Q_sub;

    // Source of vectors (bench or upstream stage)
    modport master (
        output valid_in, frame_start, din_R_add, din_Q_add, din_R_sub, din_Q_sub,
        input  valid_out, fac_out, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub
    );

    // The rotator itself
    modport slave (
        input  valid_in, frame_start, din_R_add, din_Q_add, din_R_sub, din_Q_sub,
        output valid_out, fac_out, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub
    );
endinterface

// File: rtl/imul_fac8_0.sv
// imul_fac8_0: inverse-FFT radix-8 twiddle stage applying W^0 or +j to the
// sub branch of a butterfly vector, alternating per accepted vector within a
// frame. One cycle latency, one vector per cycle.
// Build option: define IMUL_FAC8_SAT_EN to saturate -(-2^(WIDTH-1)) to
// 2^(WIDTH-1)-1 instead of letting the negation wrap.
//
// state | meaning
// S_W0  | next accepted vector (without frame_start) uses W^0
// S_PJ  | next accepted vector (without frame_start) uses +j
module imul_fac8_0 #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    imul_fac8_0_if.slave bus
);
    localparam logic S_W0 = 1'b0;
    localparam logic S_PJ = 1'b1;

    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic                        r_state;
    logic                        w_state_nxt;
    logic                        w_fac;
    logic [DEPTH-1:0][WIDTH-1:0] w_R_sub;
    logic [DEPTH-1:0][WIDTH-1:0] w_Q_sub;

    logic                        r_valid_out;
    logic                        r_fac_out;
    logic [DEPTH-1:0][WIDTH-1:0] r_R_add;
    logic [DEPTH-1:0][WIDTH-1:0] r_Q_add;
    logic [DEPTH-1:0][WIDTH-1:0] r_R_sub;
    logic [DEPTH-1:0][WIDTH-1:0] r_Q_sub;

    // Factor-select state register; reset restarts the frame at W^0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_W0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next factor: frame_start forces +j next, otherwise alternate; hold when idle
    always_comb begin
        w_state_nxt = r_state;
        if (bus.valid_in) begin
            if (bus.frame_start) begin
                w_state_nxt = S_PJ;
            end else begin
                w_state_nxt = (r_state == S_PJ) ? S_W0 : S_PJ;
            end
        end
    end

    // Factor for the current vector and the rotated sub branch: +j maps
    // (R, Q) to (-Q, R)
    always_comb begin
        w_fac   = bus.frame_start ? 1'b0 : (r_state == S_PJ);
        w_R_sub = bus.din_R_sub;
        w_Q_sub = bus.din_Q_sub;
        if (w_fac) begin
            for (int k = 0; k < DEPTH; k++) begin
`ifdef IMUL_FAC8_SAT_EN
                w_R_sub[k] = (bus.din_Q_sub[k] == C_MIN) ? C_MAX : -bus.din_Q_sub[k];
`else
                w_R_sub[k] = -bus.din_Q_sub[k];
`endif
                w_Q_sub[k] = bus.din_R_sub[k];
            end
        end
    end

    // Output register: load on accepted vector, hold data when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_fac_out   <= 1'b0;
            r_R_add     <= '0;
            r_Q_add     <= '0;
            r_R_sub     <= '0;
            r_Q_sub     <= '0;
        end else begin
            r_valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                r_fac_out <= w_fac;
                r_R_add   <= bus.din_R_add;
                r_Q_add   <= bus.din_Q_add;
                r_R_sub   <= w_R_sub;
                r_Q_sub   <= w_Q_sub;
            end
        end
    end

    assign bus.valid_out  = r_valid_out;
    assign bus.fac_out    = r_fac_out;
    assign bus.dout_R_add = r_R_add;
    assign bus.dout_Q_add = r_Q_add;
    assign bus.dout_R_sub = r_R_sub;
    assign bus.dout_Q_sub = r_Q_sub;

    // Sanity: the negation limit constants only matter with saturation enabled
    logic w_unused;
    assign w_unused = ^{C_MIN, C_MAX};
endmodule

// File: tb/tb_imul_fac8_0.sv
// Self-checking bench for imul_fac8_0: directed scenarios plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_imul_fac8_0;
    localparam int W = 10;
    localparam int D = 16;
`ifdef IMUL_FAC8_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [D-1:0][W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imul_fac8_0_if #(.WIDTH(W), .DEPTH(D)) bus ();

    imul_fac8_0 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_fac = 0;
    logic e_valid, e_fac;
    vec_t e_Ra, e_Qa, e_Rs, e_Qs;

    function automatic logic [W-1:0] m_neg(input logic [W-1:0] x);
        int v;
        v = -int'($signed(x));
        if (v > (2**(W-1)) - 1) v = SAT ? (2**(W-1)) - 1 : v - 2**W;
        return W'(v);
    endfunction

    function automatic int lane(input vec_t v, input int k);
        return int'($signed(v[k]));
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        int f;
        @(posedge clk);
        if (rst) begin
            m_fac = 0; e_valid = 0; e_fac = 0;
            e_Ra = '0; e_Qa = '0; e_Rs = '0; e_Qs = '0;
        end else if (bus.valid_in) begin
            f = bus.frame_start ? 0 : m_fac;
            m_fac = bus.frame_start ? 1 : 1 - m_fac;
            e_valid = 1; e_fac = f[0];
            e_Ra = bus.din_R_add; e_Qa = bus.din_Q_add;
            for (int k = 0; k < D; k++) begin
                e_Rs[k] = f ? m_neg(bus.din_Q_sub[k]) : bus.din_R_sub[k];
                e_Qs[k] = f ? bus.din_R_sub[k] : bus.din_Q_sub[k];
            end
        end else begin
            e_valid = 0;
        end
        #1;
    endtask

    task automatic set_pattern();
        for (int k = 0; k < D; k++) begin
            bus.din_R_add[k] = W'(5 * k);
            bus.din_R_sub[k] = W'(7 * k - 50);
            bus.din_Q_add[k] = W'(3 * k + 10);
            bus.din_Q_sub[k] = W'((15 - k) * 6 - 20);
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < D; k++) begin
            bus.din_R_add[k] = W'($urandom);
            bus.din_Q_add[k] = W'($urandom);
            bus.din_R_sub[k] = W'($urandom);
            bus.din_Q_sub[k] = ($urandom_range(0, 7) == 0) ? W'(-512) : W'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1; bus.valid_in = 1; bus.frame_start = 0;
        set_random();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (bus.valid_out !== 1'b0 || bus.fac_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctl cyc%0d: valid_out=%b fac_out=%b, want 0 0", c, bus.valid_out, bus.fac_out);
            end
            n_checks++;
            if ({bus.dout_R_add, bus.dout_Q_add, bus.dout_R_sub, bus.dout_Q_sub} !== '0) begin
                n_fail++;
                $display("FAIL reset_dout cyc%0d: dout not all zero", c);
            end
        end
        rst = 0;
    endtask

    task automatic test_pass();
        set_pattern(); bus.valid_in = 1; bus.frame_start = 1;
        tick();
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.fac_out !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_ctl: valid_out=%b fac_out=%b, want 1 0", bus.valid_out, bus.fac_out);
        end
        n_checks++;
        if (bus.dout_R_add !== bus.din_R_add || bus.dout_Q_add !== bus.din_Q_add ||
            bus.dout_R_sub !== bus.din_R_sub || bus.dout_Q_sub !== bus.din_Q_sub) begin
            n_fail++;
            $display("FAIL pass_data: dout_R_sub=%h want %h, dout_Q_sub=%h want %h",
                     bus.dout_R_sub, bus.din_R_sub, bus.dout_Q_sub, bus.din_Q_sub);
        end
    endtask

    task automatic test_rotate();
        set_pattern(); bus.valid_in = 1; bus.frame_start = 0;
        tick();
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.fac_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rot_ctl: valid_out=%b fac_out=%b, want 1 1", bus.valid_out, bus.fac_out);
        end
        n_checks++;
        if (lane(bus.dout_R_sub, 0) != -70 || lane(bus.dout_Q_sub, 0) != -50) begin
            n_fail++;
            $display("FAIL rot_lane0: R_sub=%0d Q_sub=%0d, want -70 -50",
                     lane(bus.dout_R_sub, 0), lane(bus.dout_Q_sub, 0));
        end
        n_checks++;
        if (lane(bus.dout_R_sub, 15) != 20 || lane(bus.dout_Q_sub, 15) != 55) begin
            n_fail++;
            $display("FAIL rot_lane15: R_sub=%0d Q_sub=%0d, want 20 55",
                     lane(bus.dout_R_sub, 15), lane(bus.dout_Q_sub, 15));
        end
        n_checks++;
        if (bus.dout_R_add !== bus.din_R_add || bus.dout_Q_add !== bus.din_Q_add ||
            bus.dout_R_sub !== e_Rs || bus.dout_Q_sub !== e_Qs) begin
            n_fail++;
            $display("FAIL rot_all: R_sub=%h want %h Q_sub=%h want %h", bus.dout_R_sub, e_Rs, bus.dout_Q_sub, e_Qs);
        end
    endtask

    task automatic test_stall();
        logic want_fac[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 4; v++) begin
            set_random(); bus.valid_in = 1; bus.frame_start = (v == 0);
            tick();
            n_checks++;
            if (bus.valid_out !== 1'b1 || bus.fac_out !== want_fac[v] ||
                bus.dout_R_sub !== e_Rs || bus.dout_Q_sub !== e_Qs ||
                bus.dout_R_add !== e_Ra || bus.dout_Q_add !== e_Qa) begin
                n_fail++;
                $display("FAIL stall_vec%0d: valid_out=%b fac_out=%b want 1 %b, R_sub=%h want %h",
                         v, bus.valid_out, bus.fac_out, want_fac[v], bus.dout_R_sub, e_Rs);
            end
            if (v == 1) begin
                bus.valid_in = 0; bus.frame_start = 1;
                for (int g = 0; g < 3; g++) begin
                    set_random();
                    tick();
                    n_checks++;
                    if (bus.valid_out !== 1'b0 || bus.fac_out !== 1'b1 ||
                        bus.dout_R_sub !== e_Rs || bus.dout_Q_sub !== e_Qs ||
                        bus.dout_R_add !== e_Ra || bus.dout_Q_add !== e_Qa) begin
                        n_fail++;
                        $display("FAIL stall_gap%0d: valid_out=%b fac_out=%b want 0 1, R_sub=%h want %h",
                                 g, bus.valid_out, bus.fac_out, bus.dout_R_sub, e_Rs);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        set_random(); bus.valid_in = 1; bus.frame_start = 1;
        tick();
        set_random(); bus.frame_start = 0;
        bus.din_Q_sub[3] = W'(-512);
        tick();
        n_checks++;
        if (bus.fac_out !== 1'b1 || lane(bus.dout_R_sub, 3) != (SAT ? 511 : -512)) begin
            n_fail++;
            $display("FAIL overflow: fac_out=%b R_sub[3]=%0d, want 1 %0d",
                     bus.fac_out, lane(bus.dout_R_sub, 3), SAT ? 511 : -512);
        end
    endtask

    task automatic test_midframe_reset();
        set_random(); bus.valid_in = 1; bus.frame_start = 1;
        tick();
        set_random(); bus.frame_start = 0; rst = 1;
        tick();
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.fac_out !== 1'b0 || bus.dout_R_sub !== '0) begin
            n_fail++;
            $display("FAIL midrst_drop: valid_out=%b fac_out=%b, want 0 0", bus.valid_out, bus.fac_out);
        end
        rst = 0; set_random(); bus.frame_start = 0;
        tick();
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.fac_out !== 1'b0 ||
            bus.dout_R_sub !== bus.din_R_sub || bus.dout_Q_sub !== bus.din_Q_sub) begin
            n_fail++;
            $display("FAIL midrst_first: valid_out=%b fac_out=%b, want 1 0", bus.valid_out, bus.fac_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_random();
            bus.valid_in    = ($urandom_range(0, 3) != 0);
            bus.frame_start = ($urandom_range(0, 5) == 0);
            rst             = ($urandom_range(0, 40) == 0);
            tick();
            n_checks++;
            if (bus.valid_out !== e_valid || bus.fac_out !== e_fac ||
                bus.dout_R_add !== e_Ra || bus.dout_Q_add !== e_Qa ||
                bus.dout_R_sub !== e_Rs || bus.dout_Q_sub !== e_Qs) begin
                n_fail++;
                $display("FAIL random_c%0d: valid_out=%b/%b fac_out=%b/%b R_sub=%h want %h Q_sub=%h want %h",
                         c, bus.valid_out, e_valid, bus.fac_out, e_fac, bus.dout_R_sub, e_Rs, bus.dout_Q_sub, e_Qs);
            end
        end
        rst = 0;
    endtask

    initial begin
        bus.valid_in = 0; bus.frame_start = 0;
        bus.din_R_add = '0; bus.din_Q_add = '0; bus.din_R_sub = '0; bus.din_Q_sub = '0;
        e_valid = 0; e_fac = 0; e_Ra = '0; e_Qa = '0; e_Rs = '0; e_Qs = '0;
        @(negedge clk);
        test_reset();
        test_pass();
        test_rotate();
        test_stall();
        test_overflow();
        test_midframe_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
